class_argmax: RTL and testbench
===============================

CLASS_ARGMAX -- requirements
Module: class_argmax

Interface
REQ-001 SHALL provide parameter NUM_CLASSES, default 10, number of output-neuron scores per frame (legal range 2..16).
REQ-002 SHALL provide parameter SCORE_W, default 21, unsigned score width, matching the output-neuron accumulator width.
REQ-003 SHALL provide parameter IDX_W, default 4, class index width; ceil(log2(NUM_CLASSES)) <= IDX_W.
REQ-004 clk_i  input  1  clock; all state updates on rising edge.
REQ-005 rst_i  input  1  reset, asynchronous, active-low.
REQ-006 start_i  input  1  single-cycle pulse opening a new frame.
REQ-007 score_valid_i  input  1  score_i carries a valid score.
REQ-008 score_i  input  SCORE_W  unsigned output-neuron score, presented in class order 0..NUM_CLASSES-1.
REQ-009 score_ready_o  output  1  block accepts a score this cycle.
REQ-010 class_valid_o  output  1  result valid.
REQ-011 class_ready_i  input  1  consumer accepts the result.
REQ-012 class_o  output  IDX_W  index of the winning class.
REQ-013 max_score_o  output  SCORE_W  winning score.
REQ-014 busy_o  output  1  high in any state other than IDLE.

Function
REQ-015 SHALL implement FSM states IDLE, COLLECT and DONE.
REQ-016 IDLE: start_i=1 -> COLLECT next cycle; count, class_o and max_score_o cleared to 0 on the same edge.
REQ-017 COLLECT: score_ready_o=1 combinationally; a score is accepted on any cycle with score_valid_i=1.
REQ-018 On each accept, if count==0 or score_i > max, SHALL load max=score_i and idx=count; count then increments.
REQ-019 Ties SHALL keep the earlier (lower) index; the comparison is strict greater-than.
REQ-020 The accept of score NUM_CLASSES-1 SHALL move the FSM to DONE; class_valid_o=1 on the following cycle (latency 1 from the last accept).
REQ-021 DONE: class_o, max_score_o and class_valid_o SHALL hold stable until class_ready_i=1, then go to IDLE next cycle.
REQ-022 score_valid_i in IDLE or DONE SHALL be ignored (score_ready_o=0 in those states).
REQ-023 start_i in COLLECT SHALL abort the current frame and restart (count=0, max cleared); a score presented in that same cycle is dropped.
REQ-024 start_i in DONE SHALL be ignored.
REQ-025 Gaps (score_valid_i=0) in COLLECT SHALL stall the block with no state change; there is no timeout.
REQ-026 All outputs SHALL be registered except score_ready_o and busy_o, which decode the FSM state.

Reset
REQ-027 rst_i=0 SHALL force IDLE, count=0, class_o=0, max_score_o=0, class_valid_o=0, score_ready_o=0, busy_o=0, regardless of clock.
REQ-028 Reset in mid-frame SHALL discard all partial results; the first post-reset frame SHALL behave identically to a cold start.

Configuration
REQ-029 Macro ARGMAX_MARGIN_EN defined: adds output margin_o [SCORE_W] = max minus second-highest score, registered, valid with class_valid_o.
REQ-030 Second-highest tracking: on a new max, second=old max; else if score_i > second, second=score_i; second cleared at start and at reset.
REQ-031 Equal top scores SHALL give margin_o=0.
REQ-032 Macro undefined: no margin_o port and no second-max register; all other behaviour identical.

Structure
REQ-033 Shared package nn_pkg SHALL hold SCORE_W, IDX_W and NUM_CLASSES defaults and the FSM state typedef; output_neuron-facing widths SHALL come from it.
REQ-034 One sub-module, argmax_cmp, SHALL be used: a combinational compare/update of (max, second, idx) against an incoming score and count; the FSM and registers stay in class_argmax.

Verification
REQ-035 Scores 5,9,3,9,1,0,2,8,7,4 -> class_o=1, max_score_o=9, class_valid_o one cycle after 10th accept; margin_o=0 if enabled.
REQ-036 Scores 0..9 ascending with score_valid_i toggled every other cycle -> class_o=9, max=9, margin_o=1; no state change on idle cycles.
REQ-037 All scores 0x1FFFFF -> class_o=0, max_score_o=0x1FFFFF (full-width compare, no overflow).
REQ-038 start_i pulsed after 4 scores, then 10 new scores with max 100 at index 6 -> class_o=6; pre-restart scores have no effect.
REQ-039 rst_i asserted after 7 scores, released, new frame of all-zero scores -> class_o=0, max_score_o=0; all outputs 0 during reset.
REQ-040 class_ready_i held low 5 cycles in DONE, start_i and score_valid_i pulsed meanwhile -> outputs stable and ignored; IDLE one cycle after class_ready_i=1.

Source files
------------

// File: rtl/nn_pkg.sv
// Shared widths and FSM state type for the output-neuron / argmax slice.
package nn_pkg;
  localparam int NUM_CLASSES_DEF = 10;
  localparam int SCORE_W_DEF     = 21;
  localparam int IDX_W_DEF       = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DONE    = 2'd2
  } state_e;
endpackage

// File: rtl/argmax_cmp.sv
// Combinational compare/update of the running (max, idx[, second]) against one score.
// ARGMAX_MARGIN_EN adds the second-highest tracking path.
module argmax_cmp
  import nn_pkg::*;
#(
  parameter int SCORE_W = SCORE_W_DEF,
  parameter int IDX_W   = IDX_W_DEF
) (
  input  logic [SCORE_W-1:0] score_i,
  input  logic [IDX_W-1:0]   count_i,
  input  logic [SCORE_W-1:0] max_i,
  input  logic [IDX_W-1:0]   idx_i,
`ifdef ARGMAX_MARGIN_EN
  input  logic [SCORE_W-1:0] second_i,
  output logic [SCORE_W-1:0] second_o,
`endif
  output logic [SCORE_W-1:0] max_o,
  output logic [IDX_W-1:0]   idx_o
);
  logic new_max;

  // Strict greater-than so ties keep the lower index.
  assign new_max = (count_i == '0) || (score_i > max_i);

  always_comb begin
    max_o = new_max ? score_i : max_i;
    idx_o = new_max ? count_i : idx_i;
`ifdef ARGMAX_MARGIN_EN
    if (new_max)               second_o = max_i;
    else if (score_i > second_i) second_o = score_i;
    else                       second_o = second_i;
`endif
  end
endmodule

// File: rtl/class_argmax.sv
// Frame-based argmax over NUM_CLASSES output-neuron scores with a valid/ready result.
// ARGMAX_MARGIN_EN adds margin_o = max minus second-highest score.
module class_argmax
  import nn_pkg::*;
#(
  parameter int NUM_CLASSES = NUM_CLASSES_DEF,
  parameter int SCORE_W     = SCORE_W_DEF,
  parameter int IDX_W       = IDX_W_DEF
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic               score_valid_i,
  input  logic [SCORE_W-1:0] score_i,
  output logic               score_ready_o,
  output logic               class_valid_o,
  input  logic               class_ready_i,
  output logic [IDX_W-1:0]   class_o,
  output logic [SCORE_W-1:0] max_score_o,
`ifdef ARGMAX_MARGIN_EN
  output logic [SCORE_W-1:0] margin_o,
`endif
  output logic               busy_o
);
  state_e             state_q, state_d;
  logic [IDX_W-1:0]   count_q, count_d;
  logic [IDX_W-1:0]   idx_q, idx_d, idx_n;
  logic [SCORE_W-1:0] max_q, max_d, max_n;
  logic               valid_q, valid_d;
  logic               last;
`ifdef ARGMAX_MARGIN_EN
  logic [SCORE_W-1:0] second_q, second_d, second_n;
  logic [SCORE_W-1:0] margin_q, margin_d;
`endif

  argmax_cmp #(.SCORE_W(SCORE_W), .IDX_W(IDX_W)) u_cmp (
    .score_i  (score_i),
    .count_i  (count_q),
    .max_i    (max_q),
    .idx_i    (idx_q),
`ifdef ARGMAX_MARGIN_EN
    .second_i (second_q),
    .second_o (second_n),
`endif
    .max_o    (max_n),
    .idx_o    (idx_n)
  );

  assign last = (count_q == IDX_W'(NUM_CLASSES - 1));

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    idx_d   = idx_q;
    max_d   = max_q;
    valid_d = valid_q;
`ifdef ARGMAX_MARGIN_EN
    second_d = second_q;
    margin_d = margin_q;
`endif
    unique case (state_q)
      IDLE, COLLECT: begin
        // start_i opens or restarts a frame; a score in the same cycle is dropped.
        if (start_i) begin
          state_d = COLLECT;
          count_d = '0;
          idx_d   = '0;
          max_d   = '0;
`ifdef ARGMAX_MARGIN_EN
          second_d = '0;
          margin_d = '0;
`endif
        end else if (state_q == COLLECT && score_valid_i) begin
          idx_d   = idx_n;
          max_d   = max_n;
          count_d = count_q + IDX_W'(1);
`ifdef ARGMAX_MARGIN_EN
          second_d = second_n;
          margin_d = max_n - second_n;
`endif
          if (last) begin
            state_d = DONE;
            valid_d = 1'b1;
          end
        end
      end
      DONE: begin
        if (class_ready_i) begin
          state_d = IDLE;
          valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= IDLE;
      count_q  <= '0;
      idx_q    <= '0;
      max_q    <= '0;
      valid_q  <= 1'b0;
`ifdef ARGMAX_MARGIN_EN
      second_q <= '0;
      margin_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      idx_q    <= idx_d;
      max_q    <= max_d;
      valid_q  <= valid_d;
`ifdef ARGMAX_MARGIN_EN
      second_q <= second_d;
      margin_q <= margin_d;
`endif
    end
  end

  assign score_ready_o = (state_q == COLLECT);
  assign busy_o        = (state_q != IDLE);
  assign class_valid_o = valid_q;
  assign class_o       = idx_q;
  assign max_score_o   = max_q;
`ifdef ARGMAX_MARGIN_EN
  assign margin_o      = margin_q;
`endif
endmodule

// File: tb/tb_class_argmax.sv
// Self-checking bench for class_argmax: directed frames plus randomized frames against a sort-based model.
`timescale 1ns/1ps
module tb_class_argmax;
  localparam int NC = 10;
  localparam int SW = 21;
  localparam int IW = 4;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b0;
  logic          start_i = 1'b0;
  logic          score_valid_i = 1'b0;
  logic [SW-1:0] score_i = '0;
  logic          score_ready_o;
  logic          class_valid_o;
  logic          class_ready_i = 1'b0;
  logic [IW-1:0] class_o;
  logic [SW-1:0] max_score_o;
`ifdef ARGMAX_MARGIN_EN
  logic [SW-1:0] margin_o;
`endif
  logic          busy_o;

  int n_cmp = 0;
  int n_bad = 0;

  class_argmax #(.NUM_CLASSES(NC), .SCORE_W(SW), .IDX_W(IW)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .start_i       (start_i),
    .score_valid_i (score_valid_i),
    .score_i       (score_i),
    .score_ready_o (score_ready_o),
    .class_valid_o (class_valid_o),
    .class_ready_i (class_ready_i),
    .class_o       (class_o),
    .max_score_o   (max_score_o),
`ifdef ARGMAX_MARGIN_EN
    .margin_o      (margin_o),
`endif
    .busy_o        (busy_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference: winner is the first index holding the largest value; margin is top minus runner-up of the sorted multiset.
  function automatic void ref_model(input int unsigned sc[$], output int unsigned eidx,
                                    output int unsigned emax, output int unsigned emarg);
    int unsigned srt[$];
    srt = sc;
    srt.rsort();
    emax  = srt[0];
    emarg = srt[0] - srt[1];
    eidx  = 0;
    for (int i = sc.size() - 1; i >= 0; i--) if (sc[i] == emax) eidx = i;
  endfunction

  task automatic tick();
    @(posedge clk_i); #1;
  endtask

  task automatic pulse_start();
    start_i = 1'b1; tick(); start_i = 1'b0;
  endtask

  task automatic feed(input int unsigned s);
    score_valid_i = 1'b1; score_i = SW'(s); tick(); score_valid_i = 1'b0;
  endtask

  task automatic ack();
    class_ready_i = 1'b1; tick(); class_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    start_i = 1'b1; score_valid_i = 1'b1; score_i = 21'h1234;
    repeat (3) tick();
    n_cmp++; if ({class_valid_o, score_ready_o, busy_o, class_o, max_score_o} !== '0) begin
      n_bad++; $display("FAIL reset_outputs: got v=%b r=%b b=%b c=%0d m=%0d want all 0",
                        class_valid_o, score_ready_o, busy_o, class_o, max_score_o); end
`ifdef ARGMAX_MARGIN_EN
    n_cmp++; if (margin_o !== '0) begin n_bad++; $display("FAIL reset_margin: got %0d want 0", margin_o); end
`endif
    start_i = 1'b0; score_valid_i = 1'b0;
    rst_i = 1'b1; tick();
    n_cmp++; if (busy_o !== 1'b0) begin n_bad++; $display("FAIL reset_release_idle: busy %b want 0", busy_o); end
  endtask

  task automatic test_req035();
    int unsigned sc[10] = '{5, 9, 3, 9, 1, 0, 2, 8, 7, 4};
    pulse_start();
    n_cmp++; if ({busy_o, score_ready_o, class_o, max_score_o} !== {2'b11, 4'd0, 21'd0}) begin
      n_bad++; $display("FAIL t035_open: busy=%b rdy=%b c=%0d m=%0d want 1 1 0 0", busy_o, score_ready_o, class_o, max_score_o); end
    for (int i = 0; i < 10; i++) begin
      n_cmp++; if (class_valid_o !== 1'b0) begin n_bad++; $display("FAIL t035_early_valid: at %0d got 1 want 0", i); end
      feed(sc[i]);
    end
    n_cmp++; if (class_valid_o !== 1'b1) begin n_bad++; $display("FAIL t035_valid: got %b want 1", class_valid_o); end
    n_cmp++; if (class_o !== 4'd1) begin n_bad++; $display("FAIL t035_class: got %0d want 1", class_o); end
    n_cmp++; if (max_score_o !== 21'd9) begin n_bad++; $display("FAIL t035_max: got %0d want 9", max_score_o); end
    n_cmp++; if (score_ready_o !== 1'b0) begin n_bad++; $display("FAIL t035_ready_done: got %b want 0", score_ready_o); end
`ifdef ARGMAX_MARGIN_EN
    n_cmp++; if (margin_o !== 21'd0) begin n_bad++; $display("FAIL t035_margin: got %0d want 0", margin_o); end
`endif
    ack();
    n_cmp++; if ({class_valid_o, busy_o} !== 2'b00) begin
      n_bad++; $display("FAIL t035_to_idle: valid=%b busy=%b want 0 0", class_valid_o, busy_o); end
  endtask

  task automatic test_gaps036();
    pulse_start();
    for (int i = 0; i < 10; i++) begin
      feed(i);
      if (i < 9) begin
        score_i = SW'($urandom); tick();
        n_cmp++; if ({score_ready_o, class_o, max_score_o} !== {1'b1, IW'(i), SW'(i)}) begin
          n_bad++; $display("FAIL t036_gap: i=%0d rdy=%b c=%0d m=%0d want 1 %0d %0d", i, score_ready_o, class_o, max_score_o, i, i); end
      end
    end
    n_cmp++; if ({class_valid_o, class_o, max_score_o} !== {1'b1, 4'd9, 21'd9}) begin
      n_bad++; $display("FAIL t036_result: v=%b c=%0d m=%0d want 1 9 9", class_valid_o, class_o, max_score_o); end
`ifdef ARGMAX_MARGIN_EN
    n_cmp++; if (margin_o !== 21'd1) begin n_bad++; $display("FAIL t036_margin: got %0d want 1", margin_o); end
`endif
    ack();
  endtask

  task automatic test_full037();
    pulse_start();
    for (int i = 0; i < 10; i++) feed(32'h1F_FFFF);
    n_cmp++; if ({class_valid_o, class_o, max_score_o} !== {1'b1, 4'd0, 21'h1F_FFFF}) begin
      n_bad++; $display("FAIL t037_full: v=%b c=%0d m=%h want 1 0 1fffff", class_valid_o, class_o, max_score_o); end
`ifdef ARGMAX_MARGIN_EN
    n_cmp++; if (margin_o !== 21'd0) begin n_bad++; $display("FAIL t037_margin: got %0d want 0", margin_o); end
`endif
    ack();
  endtask

  task automatic test_abort038();
    int unsigned sc[$];
    int unsigned eidx, emax, emarg;
    pulse_start();
    for (int i = 0; i < 4; i++) feed(500 + i);
    start_i = 1'b1; score_valid_i = 1'b1; score_i = 21'd1000; tick();
    start_i = 1'b0; score_valid_i = 1'b0;
    n_cmp++; if ({busy_o, class_o, max_score_o} !== {1'b1, 4'd0, 21'd0}) begin
      n_bad++; $display("FAIL t038_cleared: busy=%b c=%0d m=%0d want 1 0 0", busy_o, class_o, max_score_o); end
    for (int i = 0; i < 10; i++) sc.push_back(i == 6 ? 100 : $urandom_range(0, 99));
    ref_model(sc, eidx, emax, emarg);
    for (int i = 0; i < 10; i++) feed(sc[i]);
    n_cmp++; if ({class_valid_o, class_o, max_score_o} !== {1'b1, 4'd6, 21'd100}) begin
      n_bad++; $display("FAIL t038_result: v=%b c=%0d m=%0d want 1 6 100", class_valid_o, class_o, max_score_o); end
`ifdef ARGMAX_MARGIN_EN
    n_cmp++; if (margin_o !== SW'(emarg)) begin n_bad++; $display("FAIL t038_margin: got %0d want %0d", margin_o, emarg); end
`endif
    ack();
  endtask

  task automatic test_midreset039();
    pulse_start();
    for (int i = 0; i < 7; i++) feed($urandom_range(1, 5000));
    rst_i = 1'b0; #1;
    n_cmp++; if ({class_valid_o, score_ready_o, busy_o, class_o, max_score_o} !== '0) begin
      n_bad++; $display("FAIL t039_async: v=%b r=%b b=%b c=%0d m=%0d want all 0",
                        class_valid_o, score_ready_o, busy_o, class_o, max_score_o); end
    tick(); tick();
    rst_i = 1'b1; tick();
    pulse_start();
    for (int i = 0; i < 10; i++) begin
      n_cmp++; if (class_valid_o !== 1'b0) begin n_bad++; $display("FAIL t039_early_valid: at %0d got 1 want 0", i); end
      feed(0);
    end
    n_cmp++; if ({class_valid_o, class_o, max_score_o} !== {1'b1, 4'd0, 21'd0}) begin
      n_bad++; $display("FAIL t039_result: v=%b c=%0d m=%0d want 1 0 0", class_valid_o, class_o, max_score_o); end
    ack();
  endtask

  task automatic test_done_hold040();
    int unsigned sc[$];
    int unsigned eidx, emax, emarg;
    for (int i = 0; i < 10; i++) sc.push_back($urandom_range(0, 2000));
    ref_model(sc, eidx, emax, emarg);
    pulse_start();
    for (int i = 0; i < 10; i++) feed(sc[i]);
    for (int c = 0; c < 5; c++) begin
      start_i = c[0]; score_valid_i = ~c[0]; score_i = 21'h1F_FFFF; tick();
      n_cmp++; if ({class_valid_o, busy_o, score_ready_o, class_o, max_score_o} !== {3'b110, IW'(eidx), SW'(emax)}) begin
        n_bad++; $display("FAIL t040_hold: cyc=%0d v=%b b=%b r=%b c=%0d m=%0d want 1 1 0 %0d %0d",
                          c, class_valid_o, busy_o, score_ready_o, class_o, max_score_o, eidx, emax); end
    end
    start_i = 1'b0; score_valid_i = 1'b0;
    ack();
    n_cmp++; if ({class_valid_o, busy_o} !== 2'b00) begin
      n_bad++; $display("FAIL t040_to_idle: v=%b b=%b want 0 0", class_valid_o, busy_o); end
    score_valid_i = 1'b1; tick(); score_valid_i = 1'b0;
    n_cmp++; if ({busy_o, score_ready_o, class_o, max_score_o} !== {2'b00, IW'(eidx), SW'(emax)}) begin
      n_bad++; $display("FAIL t040_idle_ignore: b=%b r=%b c=%0d m=%0d want 0 0 %0d %0d",
                        busy_o, score_ready_o, class_o, max_score_o, eidx, emax); end
  endtask

  task automatic test_random();
    for (int f = 0; f < 25; f++) begin
      int unsigned sc[$];
      int unsigned eidx, emax, emarg;
      for (int i = 0; i < NC; i++)
        sc.push_back(f[0] ? $urandom_range(0, 7) : ($urandom & 32'h1F_FFFF));
      ref_model(sc, eidx, emax, emarg);
      pulse_start();
      for (int i = 0; i < NC; i++) begin
        repeat ($urandom_range(0, 2)) begin score_i = SW'($urandom); tick(); end
        feed(sc[i]);
      end
      n_cmp++; if ({class_valid_o, class_o, max_score_o} !== {1'b1, IW'(eidx), SW'(emax)}) begin
        n_bad++; $display("FAIL rand_result: frame=%0d v=%b c=%0d m=%0d want 1 %0d %0d",
                          f, class_valid_o, class_o, max_score_o, eidx, emax); end
`ifdef ARGMAX_MARGIN_EN
      n_cmp++; if (margin_o !== SW'(emarg)) begin
        n_bad++; $display("FAIL rand_margin: frame=%0d got %0d want %0d", f, margin_o, emarg); end
`endif
      repeat ($urandom_range(0, 2)) tick();
      ack();
    end
  endtask

  initial begin
    test_reset();
    test_req035();
    test_gaps036();
    test_full037();
    test_abort038();
    test_midreset039();
    test_done_hold040();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
